// File: rtl/rca_stream_accumulator_pkg.sv
// Shared types and sizing helpers for the ripple-carry stream accumulator.
// Contents: accumulator state enum, default WIDTH/COUNT, result/count width functions.
package rca_pkg;

  localparam int unsigned DEF_WIDTH = 6;
  localparam int unsigned DEF_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Carry counter / beat counter width: must hold the value COUNT itself.
  function automatic int unsigned cnt_width(input int unsigned count);
    return $clog2(count) + 1;
  endfunction

  // Full result width: COUNT * 2^WIDTH is the largest reachable total.
  function automatic int unsigned res_width(input int unsigned width, input int unsigned count);
    return width + cnt_width(count);
  endfunction

endpackage

// File: rtl/rca_stream_accumulator_if.sv
// Valid/ready operand stream in, valid/ready result out.
// Signals: in_valid/in_ready/in_data/in_cin (beat), out_valid/out_ready/out_sum/out_beats
// (result), flush when RCA_ACC_FLUSH_EN is defined.
// Modports: master = stream source / result sink, slave = accumulator.
interface rca_stream_accumulator_if
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned COUNT = DEF_COUNT
);

  localparam int unsigned RESW = res_width(WIDTH, COUNT);
  localparam int unsigned CNTW = cnt_width(COUNT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [RESW-1:0]  out_sum;
  logic [CNTW-1:0]  out_beats;
`ifdef RCA_ACC_FLUSH_EN
  logic             flush;

  modport master (
    output in_valid, in_data, in_cin, out_ready, flush,
    input  in_ready, out_valid, out_sum, out_beats
  );
  modport slave (
    input  in_valid, in_data, in_cin, out_ready, flush,
    output in_ready, out_valid, out_sum, out_beats
  );
`else
  modport master (
    output in_valid, in_data, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_beats
  );
  modport slave (
    input  in_valid, in_data, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_beats
  );
`endif

endinterface

// File: rtl/rca_acc_adder_stage.sv
// Combinational WIDTH-bit ripple-carry adder: sum = a + b + cin, carry out on cout.
// Ports: a, b (operands), cin (carry in), sum, cout.
module rca_acc_adder_stage #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/rca_stream_accumulator.sv
// Sums COUNT operand beats (plus per-beat carry-in) through a ripple-carry stage,
// extending the carry into a high counter, and presents the exact total on a
// registered valid/ready output.
// Ports: clk, rst_n (async active-low), bus (rca_stream_accumulator_if.slave).
// Optional: RCA_ACC_FLUSH_EN adds bus.flush to close an accumulation early.
module rca_stream_accumulator
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned COUNT = DEF_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  rca_stream_accumulator_if.slave bus
);

  localparam int unsigned HIW  = cnt_width(COUNT);
  localparam int unsigned RESW = res_width(WIDTH, COUNT);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [HIW-1:0]   acc_hi_q, acc_hi_d;
  logic [HIW-1:0]   cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [RESW-1:0]  out_sum_q, out_sum_d;
  logic [HIW-1:0]   out_beats_q, out_beats_d;

  logic             in_ready_c;
  logic             xfer_c;
  logic [WIDTH-1:0] add_a_c;
  logic [WIDTH-1:0] add_sum_c;
  logic             add_cout_c;

  // Ready depends on state only, never on in_valid.
  assign in_ready_c = (state_q != DONE);
  assign xfer_c     = bus.in_valid && in_ready_c;
  // A fresh accumulation starts from zero without needing acc_lo cleared first.
  assign add_a_c    = (state_q == IDLE) ? '0 : acc_lo_q;

  rca_acc_adder_stage #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a_c),
    .b    (bus.in_data),
    .cin  (bus.in_cin),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_lo_q    <= '0;
      acc_hi_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_lo_q    <= acc_lo_d;
      acc_hi_q    <= acc_hi_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
    end
  end

  // Next-state and next-register values; everything holds unless a transfer or handshake occurs.
  always_comb begin
    state_d     = state_q;
    acc_lo_d    = acc_lo_q;
    acc_hi_d    = acc_hi_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;

    unique case (state_q)
      IDLE: begin
        if (xfer_c) begin
          acc_lo_d = add_sum_c;
          acc_hi_d = HIW'(add_cout_c);
          cnt_d    = HIW'(1);
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer_c) begin
          acc_lo_d = add_sum_c;
          acc_hi_d = HIW'(acc_hi_q + HIW'(add_cout_c));
          cnt_d    = HIW'(cnt_q + HIW'(1));
          if (cnt_d == HIW'(COUNT)) state_d = DONE;
        end
`ifdef RCA_ACC_FLUSH_EN
        // Any beat taken this cycle is already folded in above.
        if (bus.flush) state_d = DONE;
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          acc_lo_d    = '0;
          acc_hi_d    = '0;
          cnt_d       = '0;
          out_sum_d   = '0;
          out_beats_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the total once, on entry to DONE, so it stays stable under backpressure.
    if (state_q != DONE && state_d == DONE) begin
      out_sum_d   = {acc_hi_d, acc_lo_d};
      out_beats_d = cnt_d;
    end

    out_valid_d = (state_d == DONE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;

endmodule

// File: doc/rca_stream_accumulator.md
Name: rca_stream_accumulator

Overview:
- Sequential stage directly downstream of the ripple-carry adder datapath. Consumes a valid/ready stream of WIDTH-bit operands with per-beat carry-in.
- Sums exactly COUNT beats through a WIDTH-bit ripple-carry stage and extends the result with a carry counter. The full, exact total is presented on a registered valid/ready output.

Parameters:
- WIDTH, 6, operand width and ripple-carry stage width.
- COUNT, 4, beats per accumulation (COUNT >= 2).
- RESW, WIDTH+$clog2(COUNT)+1, result width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  operand.
- in_cin  input  1  carry-in added with in_data.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  RESW  accumulated total.
- out_beats  output  $clog2(COUNT)+1  beats summed into out_sum.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc_lo=0, acc_hi=0, beat_cnt=0, out_valid=0, out_sum=0, out_beats=0. in_ready=1 in the first cycle after release.
- Beat transfer: in_valid && in_ready on a rising edge. in_data and in_cin are sampled only on transfer; they are ignored otherwise.
- Adder A input is 0 in IDLE, otherwise acc_lo. B input is in_data; carry-in is in_cin.
- On transfer:
  - acc_lo <= adder sum.
  - acc_hi <= acc_hi + adder carry-out. In IDLE, acc_hi <= carry-out.
  - beat_cnt increments.
- States:
  - IDLE: in_ready=1, out_valid=0. A transfer goes to ACCUM with beat_cnt=1.
  - ACCUM: in_ready=1, out_valid=0. A transfer that makes beat_cnt==COUNT goes to DONE. No transfer: hold all state; gaps of any length are allowed.
  - DONE: in_ready=0, out_valid=1, out_sum={acc_hi,acc_lo}, out_beats=beat_cnt.
    - out_valid && out_ready goes to IDLE; acc, beat_cnt and outputs are cleared next cycle.
    - Otherwise hold; out_sum and out_beats stay stable while out_valid=1.
- Latency: out_valid rises the cycle after the COUNT-th beat transfer.
- Throughput: one accumulation per COUNT+1 cycles minimum. DONE→IDLE costs one cycle with in_ready=0.
- Width rule: acc_hi is $clog2(COUNT)+1 bits and never wraps. The maximum total COUNT*2^WIDTH fits RESW.
- in_ready is combinational from state only, with no dependence on in_valid. out_valid is a registered state decode.
- Reset mid-operation (any state): immediate return to reset values; the partial sum is discarded and no output is produced.
- X on in_data/in_cin while in_valid=0 must not propagate into the registers.

Optional Feature:
- Macro: RCA_ACC_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 in ACCUM goes to DONE next cycle with out_beats=beat_cnt (< COUNT).
  - A beat transferred in the same cycle as flush is included first.
  - flush in IDLE or DONE is ignored.
- Undefined: no flush port; only COUNT beats end an accumulation.

Decomposition:
- Package rca_pkg holds:
  - state enum acc_state_e {IDLE, ACCUM, DONE};
  - function res_width(WIDTH, COUNT);
  - default WIDTH/COUNT constants.
- One sub-module: rca_acc_adder_stage. Combinational WIDTH-bit full-adder chain with ports a, b, cin, sum, cout. It is instantiated once; all state lives in the parent.

Test Plan:
- Basic sum (WIDTH=6, COUNT=4): beats 3,5,4,6 with cin 0,0,1,1 back-to-back → out_valid 1 cycle after 4th beat, out_sum=20, out_beats=4.
- Carry extension: four beats of 63 with cin=1 → out_sum=256 (9'b1_0000_0000), acc_lo=0, acc_hi=4.
- Backpressure: after DONE, hold out_ready=0 for 5 cycles → out_valid=1, in_ready=0, out_sum stable. out_ready=1 → IDLE next cycle, in_ready=1, out_sum=0.
- Input gaps: beats 10,20,30,1 (cin=0) with in_valid low 3 cycles between each → out_sum=61; garbage on in_data during gaps has no effect.
- Reset mid-operation: after 2 beats (7,7), pulse rst_n low mid-cycle → outputs 0 immediately. Then beats 1,1,1,1 → out_sum=4.
- (RCA_ACC_FLUSH_EN) beats 9,9 then flush=1 with beat 2 → out_sum=20, out_beats=3.
